// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the MEM-stage data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BLOCK_WORDS = 4;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned OFFSET_LSB  = 2;
  localparam int unsigned INDEX_LSB   = 4;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    WDONE
  } dcache_state_e;

  // One backing-memory beat as presented on the request bus.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Tag width for a given number of index bits.
  function automatic int unsigned tag_width(input int unsigned index_bits);
    return ADDR_W - INDEX_LSB - index_bits;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped cache with 4-word lines.
// Ports: clk, rst (async active-low, clears valid bits only);
//   read port rd_index/rd_offset -> rd_valid, rd_tag, rd_word (combinational);
//   write port wr_word_en/wr_index/wr_offset/wr_word (one word),
//   wr_tag_en/wr_tag (writes tag and sets valid for wr_index).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_W      = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [DATA_W-1:0]      rd_word,
  input  logic                   wr_word_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [DATA_W-1:0]      wr_word,
  input  logic                   wr_tag_en,
  input  logic [TAG_W-1:0]       wr_tag
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][BLOCK_WORDS];

  // Valid bits: the only reset state in the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_tag_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage, no reset.
  always_ff @(posedge clk) begin
    if (wr_tag_en) begin
      tag_q[wr_index] <= wr_tag;
    end
    if (wr_word_en) begin
      data_q[wr_index][wr_offset] <= wr_word;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage data access: direct-mapped write-through, no-write-allocate
// cache with 4-word line refill from a req/ack backing memory.
// Ports: clk, rst (async active-low);
//   pipeline side: mem_read_i, mem_write_i, addr_i, wdata_i -> rdata_o, stall_o
//     (rdata_o/stall_o are combinational, forced 0 in reset);
//   backing side: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o (registered),
//     mem_ack_i, mem_rdata_i;
//   statistics: hit_cnt_o, miss_cnt_o (load hits/misses, wrap mod 2^32).
module mem_stage_dcache
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned TAG_W = tag_width(INDEX_BITS);
  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(BLOCK_WORDS - 1);

  // Address fields; byte offset bits are ignored.
  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_W-1:0]       tag;
  logic                   unused_byte_bits;

  assign offset           = addr_i[OFFSET_LSB +: OFFSET_BITS];
  assign index            = addr_i[INDEX_LSB +: INDEX_BITS];
  assign tag              = addr_i[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^addr_i[OFFSET_LSB-1:0];

  // Array interface.
  logic                   arr_valid;
  logic [TAG_W-1:0]       arr_tag;
  logic [DATA_W-1:0]      arr_word;
  logic                   arr_word_en;
  logic [OFFSET_BITS-1:0] arr_wr_offset;
  logic [DATA_W-1:0]      arr_wr_word;
  logic                   arr_tag_en;
  logic                   hit;

  dcache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (index),
    .rd_offset (offset),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_word   (arr_word),
    .wr_word_en(arr_word_en),
    .wr_index  (index),
    .wr_offset (arr_wr_offset),
    .wr_word   (arr_wr_word),
    .wr_tag_en (arr_tag_en),
    .wr_tag    (tag)
  );

  assign hit = arr_valid && (arr_tag == tag);

  // State and registered outputs.
  dcache_state_e          state_q, state_d;
  logic [OFFSET_BITS-1:0] beat_q, beat_d;
  logic                   req_vld_q, req_vld_d;
  mem_req_t               req_q, req_d;
  logic [31:0]            hit_cnt_q, miss_cnt_q;
  logic                   hit_inc, miss_inc;
  logic                   stall_c;
  logic [DATA_W-1:0]      rdata_c;

  // State register, request register and statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      req_vld_q  <= 1'b0;
      req_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      req_vld_q <= req_vld_d;
      req_q     <= req_d;
      if (hit_inc) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_inc) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  // Next state, request generation and array writes.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    req_vld_d     = req_vld_q;
    req_d         = req_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    stall_c       = 1'b0;
    rdata_c       = '0;
    arr_word_en   = 1'b0;
    arr_tag_en    = 1'b0;
    arr_wr_offset = offset;
    arr_wr_word   = wdata_i;

    case (state_q)
      IDLE: begin
        // A simultaneous read and write is handled as a write.
        if (mem_write_i) begin
          stall_c     = 1'b1;
          state_d     = WRITE;
          req_vld_d   = 1'b1;
          req_d.we    = 1'b1;
          req_d.addr  = {addr_i[ADDR_W-1:OFFSET_LSB], 2'b00};
          req_d.wdata = wdata_i;
        end else if (mem_read_i) begin
          if (hit) begin
            rdata_c = arr_word;
            hit_inc = 1'b1;
          end else begin
            stall_c    = 1'b1;
            state_d    = REFILL;
            miss_inc   = 1'b1;
            beat_d     = '0;
            req_vld_d  = 1'b1;
            req_d.we   = 1'b0;
            req_d.addr = {addr_i[ADDR_W-1:INDEX_LSB], {OFFSET_BITS{1'b0}}, 2'b00};
          end
        end
      end

      REFILL: begin
        stall_c = 1'b1;
        if (mem_ack_i) begin
          arr_word_en   = 1'b1;
          arr_wr_offset = beat_q;
          arr_wr_word   = mem_rdata_i;
          beat_d        = OFFSET_BITS'(beat_q + 2'd1);
          if (beat_q == LAST_BEAT) begin
            // Last beat: the line becomes valid and the load replays as a hit.
            arr_tag_en = 1'b1;
            req_vld_d  = 1'b0;
            beat_d     = '0;
            state_d    = IDLE;
          end else begin
            req_d.addr = {addr_i[ADDR_W-1:INDEX_LSB], beat_d, 2'b00};
          end
        end
      end

      WRITE: begin
        stall_c = 1'b1;
        if (mem_ack_i) begin
          // Write-through; only a resident line is updated (no allocate).
          arr_word_en = hit;
          req_vld_d   = 1'b0;
          state_d     = WDONE;
        end
      end

      WDONE: begin
        // Release the pipeline for one cycle so the store retires.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_o     = rst & stall_c;
  assign rdata_o     = rst ? rdata_c : '0;
  assign mem_req_o   = req_vld_q;
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: directed vector table, reset-mid-refill
// sequence, and random accesses checked against a cache model.
module tb_mem_stage_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i, hit_cnt_o, miss_cnt_o;

  always #5 clk = ~clk;

  mem_stage_dcache #(.INDEX_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read_i (mem_read_i),
    .mem_write_i(mem_write_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Initial backing-memory contents.
  function automatic logic [31:0] init_val(input logic [31:0] wa);
    if (wa >= 32'h40 && wa <= 32'h4C) return 32'hA0 + ((wa - 32'h40) >> 2);
    return wa ^ 32'h5A5A_0000;
  endfunction

  // ---------------- backing memory responder ----------------
  logic [31:0] resp_mem [logic [31:0]];
  int          rlat = 0;
  int          wcnt = 0;
  bit          pend = 0;
  logic [31:0] l_addr, l_wd;
  logic        l_we;
  int          rbeats = 0, wbeats = 0;
  logic [31:0] log_addr [$];
  logic [31:0] log_wd   [$];
  logic        log_we   [$];

  function automatic logic [31:0] rget(input logic [31:0] wa);
    return resp_mem.exists(wa) ? resp_mem[wa] : init_val(wa);
  endfunction

  always @(negedge clk) begin
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      pend = 0;
      wcnt = 0;
    end
    if (!mem_req_o) begin
      pend = 0;
      wcnt = 0;
    end else begin
      if (!pend) begin
        pend   = 1;
        l_addr = mem_addr_o;
        l_we   = mem_we_o;
        l_wd   = mem_wdata_o;
      end
      if (wcnt >= rlat) begin
        check("req_addr_stable", mem_addr_o, l_addr);
        check("req_we_stable", 32'(mem_we_o), 32'(l_we));
        if (mem_we_o) check("req_wdata_stable", mem_wdata_o, l_wd);
        log_addr.push_back(mem_addr_o);
        log_we.push_back(mem_we_o);
        log_wd.push_back(mem_wdata_o);
        if (mem_we_o) begin
          resp_mem[mem_addr_o] = mem_wdata_o;
          wbeats++;
        end else begin
          mem_rdata_i = rget(mem_addr_o);
          rbeats++;
        end
        mem_ack_i = 1'b1;
      end else begin
        wcnt++;
      end
    end
  end

  // ---------------- reference cache model ----------------
  bit          mv [16];
  logic [23:0] mt [16];
  logic [31:0] md [16][4];
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] m_hits = 0, m_misses = 0;

  function automatic logic [31:0] mget(input logic [31:0] wa);
    return mmem.exists(wa) ? mmem[wa] : init_val(wa);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, output bit e_stall,
                              output logic [31:0] e_rdata, output int e_rb, output int e_wb);
    int unsigned idx, off;
    logic [23:0] tg;
    logic [31:0] wa;
    idx = a[7:4];
    off = a[3:2];
    tg  = a[31:8];
    wa  = {a[31:2], 2'b00};
    e_stall = 0; e_rdata = 0; e_rb = 0; e_wb = 0;
    if (wr) begin
      e_stall = 1;
      e_wb = 1;
      mmem[wa] = d;
      if (mv[idx] && mt[idx] == tg) md[idx][off] = d;
    end else if (rd) begin
      if (!(mv[idx] && mt[idx] == tg)) begin
        e_stall = 1;
        e_rb = 4;
        m_misses++;
        for (int k = 0; k < 4; k++) md[idx][k] = mget({a[31:4], 4'(k * 4)});
        mv[idx] = 1;
        mt[idx] = tg;
      end
      m_hits++;
      e_rdata = md[idx][off];
    end
  endtask

  // ---------------- access driver ----------------
  // Called just after a rising edge; returns just after the edge that retires the access.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input int lat, output bit st0, output logic [31:0] rdat,
                           output int nrb, output int nwb, output int ncyc);
    int rb0, wb0, cyc;
    rlat = lat;
    rb0 = rbeats;
    wb0 = wbeats;
    log_addr.delete(); log_we.delete(); log_wd.delete();
    mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = d;
    @(negedge clk);
    st0 = stall_o;
    cyc = st0 ? 1 : 0;
    while (stall_o && cyc < 200) begin
      @(negedge clk);
      if (stall_o) cyc++;
    end
    if (stall_o) check("stall_timeout", 32'(stall_o), 32'd0);
    rdat = rdata_o;
    ncyc = cyc;
    @(posedge clk);
    #1;
    mem_read_i = 0; mem_write_i = 0;
    nrb = rbeats - rb0;
    nwb = wbeats - wb0;
    // Beat addresses: a full aligned line for a refill, the word for a store.
    if (nwb == 1 && log_addr.size() == 1) begin
      check("wr_beat_addr", log_addr[0], {a[31:2], 2'b00});
      check("wr_beat_data", log_wd[0], d);
    end
    if (nrb == 4 && log_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("rd_beat_addr", log_addr[k], {a[31:4], 2'(k), 2'b00});
        check("rd_beat_we", 32'(log_we[k]), 32'd0);
      end
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          stall;
    logic [31:0] rdata;
    int          rb;
    int          wb;
    int          min_cyc;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit          st0, e_stall;
    logic [31:0] rdat, e_rdata;
    int          nrb, nwb, ncyc, e_rb, e_wb, guard, rb0;

    tbl[0]  = '{1, 0, 32'h0000_0040, 32'h0,         2, 1, 32'h0000_00A0, 4, 0, 8, 1, 1};
    tbl[1]  = '{1, 0, 32'h0000_0048, 32'h0,         0, 0, 32'h0000_00A2, 0, 0, 0, 2, 1};
    tbl[2]  = '{0, 1, 32'h0000_0044, 32'hDEADBEEF,  3, 1, 32'h0,         0, 1, 0, 2, 1};
    tbl[3]  = '{1, 0, 32'h0000_0044, 32'h0,         0, 0, 32'hDEADBEEF,  0, 0, 0, 3, 1};
    tbl[4]  = '{0, 1, 32'h0000_1000, 32'h12345678,  1, 1, 32'h0,         0, 1, 0, 3, 1};
    tbl[5]  = '{1, 0, 32'h0000_1000, 32'h0,         1, 1, 32'h12345678,  4, 0, 0, 4, 2};
    tbl[6]  = '{1, 0, 32'h0000_0040, 32'h0,         0, 0, 32'h0000_00A0, 0, 0, 0, 5, 2};
    tbl[7]  = '{1, 0, 32'h0000_0440, 32'h0,         1, 1, 32'h5A5A_0440, 4, 0, 0, 6, 3};
    tbl[8]  = '{1, 0, 32'h0000_0040, 32'h0,         2, 1, 32'h0000_00A0, 4, 0, 0, 7, 4};
    tbl[9]  = '{1, 1, 32'h0000_0048, 32'hCAFEF00D,  0, 1, 32'h0,         0, 1, 0, 7, 4};
    tbl[10] = '{1, 0, 32'h0000_0048, 32'h0,         0, 0, 32'hCAFEF00D,  0, 0, 0, 8, 4};
    tbl[11] = '{1, 0, 32'h0000_004B, 32'h0,         0, 0, 32'hCAFEF00D,  0, 0, 0, 9, 4};
    tbl[12] = '{0, 0, 32'h0000_0040, 32'h0,         0, 0, 32'h0,         0, 0, 0, 9, 4};

    // Reset: combinational outputs forced low even with a load presented.
    rst = 1'b0;
    mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h40; wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #3;
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_req", 32'(mem_req_o), 32'd0);
    check("reset_we", 32'(mem_we_o), 32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_wdata", mem_wdata_o, 32'd0);
    check("reset_hits", hit_cnt_o, 32'd0);
    check("reset_misses", miss_cnt_o, 32'd0);
    mem_read_i = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      model_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, e_stall, e_rdata, e_rb, e_wb);
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat, st0, rdat, nrb, nwb, ncyc);
      check($sformatf("vec%0d_stall", i), 32'(st0), 32'(tbl[i].stall));
      check($sformatf("vec%0d_rdata", i), rdat, tbl[i].rdata);
      check($sformatf("vec%0d_rbeats", i), 32'(nrb), 32'(tbl[i].rb));
      check($sformatf("vec%0d_wbeats", i), 32'(nwb), 32'(tbl[i].wb));
      check($sformatf("vec%0d_hits", i), hit_cnt_o, tbl[i].hits);
      check($sformatf("vec%0d_misses", i), miss_cnt_o, tbl[i].misses);
      if (tbl[i].min_cyc > 0)
        check($sformatf("vec%0d_stall_cycles_ge_%0d", i, tbl[i].min_cyc),
              32'(ncyc >= tbl[i].min_cyc), 32'd1);
    end

    // Reset in the middle of a refill, after two beats.
    rlat = 1;
    rb0 = rbeats;
    mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h0000_2000;
    guard = 0;
    while ((rbeats - rb0) < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midreset_two_beats_seen", 32'(rbeats - rb0), 32'd2);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midreset_req_dropped", 32'(mem_req_o), 32'd0);
    check("midreset_stall", 32'(stall_o), 32'd0);
    check("midreset_hits", hit_cnt_o, 32'd0);
    check("midreset_misses", miss_cnt_o, 32'd0);
    mem_read_i = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_access(1, 0, 32'h0000_2000, 32'h0, e_stall, e_rdata, e_rb, e_wb);
    do_access(1, 0, 32'h0000_2000, 32'h0, 2, st0, rdat, nrb, nwb, ncyc);
    check("postreset_stall", 32'(st0), 32'd1);
    check("postreset_rbeats", 32'(nrb), 32'd4);
    check("postreset_rdata", rdat, 32'h5A5A_2000);
    check("postreset_misses", miss_cnt_o, 32'd1);
    check("postreset_hits", hit_cnt_o, 32'd1);

    // Random accesses against the model.
    for (int n = 0; n < 200; n++) begin
      bit          rd, wr;
      logic [31:0] a, d;
      int          kind;
      kind = $urandom_range(0, 19);
      rd = (kind < 10) || (kind == 16);
      wr = (kind >= 10 && kind < 17);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      model_access(rd, wr, a, d, e_stall, e_rdata, e_rb, e_wb);
      do_access(rd, wr, a, d, $urandom_range(0, 3), st0, rdat, nrb, nwb, ncyc);
      check("rand_stall", 32'(st0), 32'(e_stall));
      check("rand_rdata", rdat, e_rdata);
      check("rand_rbeats", 32'(nrb), 32'(e_rb));
      check("rand_wbeats", 32'(nwb), 32'(e_wb));
      check("rand_hits", hit_cnt_o, m_hits);
      check("rand_misses", miss_cnt_o, m_misses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
